// File: rtl/spi_pkg.sv
// Shared SPI definitions: engine state encoding, transfer geometry,
// the {cpha,cpol} mode encoding also used by the edge generator, and
// small helpers for decoding the mode and picking the outgoing bit.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

  localparam int SPI_BITS  = 8;
  localparam int SPI_EDGES = 16;

  // Mode number encoded as {cpha, cpol}
  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE2 = 2'b01,
    SPI_MODE1 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  function automatic logic mode_cpol(input spi_mode_e m);
    return m[0];
  endfunction

  function automatic logic mode_cpha(input spi_mode_e m);
    return m[1];
  endfunction

  // Bit currently at the head of a shift register for the given order
  function automatic logic head_bit(input logic [SPI_BITS-1:0] v, input logic lsb);
    return lsb ? v[0] : v[SPI_BITS-1];
  endfunction

endpackage

// File: rtl/spi_bit_shifter.sv
// Load/shift register with selectable direction. In MSB-first order data
// leaves from the top and enters at the bottom; LSB-first is the mirror.
module spi_bit_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_BITS
) (
  input  logic              clk,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift_en,
  input  logic              lsb_first,
  input  logic              sin,
  output logic [DATA_W-1:0] q
);

  // Parallel load wins over shift; the register holds otherwise
  always_ff @(posedge clk) begin
    if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= lsb_first ? {sin, q[DATA_W-1:1]} : {q[DATA_W-2:0], sin};
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: frames one byte with ss_n, kicks the edge
// generator with tx_dp, drives sclk/mosi from the edge pulses and
// assembles miso into rx_data.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int SS_LEAD  = 2,
  parameter int SS_TRAIL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       lsb_first,
  input  logic       toggling_edge,
  input  logic       sampling_edge,
  output logic       tx_dp,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ss_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  spi_state_e state, state_nxt;
  spi_mode_e  mode_q;
  logic       lsb_q;
  logic       mode_vld;
  logic       err_both;
  logic [3:0] phase_cnt;
  logic [4:0] edge_cnt;
  logic [3:0] tog_cnt;

  logic [SPI_BITS-1:0] tx_q;
  logic [SPI_BITS-1:0] rx_q;

  logic accept, in_shift, samp, tog, edge_any;
  logic lead_last, trail_last, shift_done;
  logic tx_shift, cpha_q, mosi_on;

  assign cpha_q     = mode_cpha(mode_q);
  assign accept     = tx_valid && (state == IDLE);
  assign in_shift   = (state == SHIFT);
  // A simultaneous pair is treated as a sampling edge only
  assign samp       = in_shift && sampling_edge;
  assign tog        = in_shift && toggling_edge && !sampling_edge;
  assign edge_any   = samp || tog;
  assign lead_last  = (phase_cnt == 4'(SS_LEAD - 1));
  assign trail_last = (phase_cnt == 4'(SS_TRAIL - 1));
  assign shift_done = edge_any && (edge_cnt == 5'(SPI_EDGES - 1));
  // cpha=0: first bit is already out, toggles 1..7 advance, toggle 8 holds.
  // cpha=1: toggle 1 exposes the first bit, toggles 2..8 advance.
  assign tx_shift   = tog && (cpha_q ? (tog_cnt != 4'd0) : (tog_cnt < 4'(SPI_BITS - 1)));
  assign mosi_on    = !cpha_q || (tog_cnt != 4'd0);

  spi_bit_shifter u_tx_shifter (
    .clk       (clk),
    .load      (accept),
    .load_data (tx_data),
    .shift_en  (tx_shift),
    .lsb_first (lsb_q),
    .sin       (1'b0),
    .q         (tx_q)
  );

  spi_bit_shifter u_rx_shifter (
    .clk       (clk),
    .load      (accept),
    .load_data ('0),
    .shift_en  (samp),
    .lsb_first (lsb_q),
    .sin       (miso),
    .q         (rx_q)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and framing outputs
  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    busy      = 1'b1;
    ss_n      = 1'b0;
    tx_dp     = 1'b0;
    mosi      = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        ss_n     = 1'b1;
        if (tx_valid) state_nxt = LEAD;
      end
      LEAD: begin
        mosi = mosi_on && head_bit(tx_q, lsb_q);
        if (lead_last) begin
          tx_dp     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        mosi = mosi_on && head_bit(tx_q, lsb_q);
        if (shift_done) state_nxt = TRAIL;
      end
      TRAIL: begin
        mosi = mosi_on && head_bit(tx_q, lsb_q);
        if (trail_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Mode capture, phase/edge counting, sclk generation and result hand-off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= SPI_MODE0;
      lsb_q     <= 1'b0;
      mode_vld  <= 1'b0;
      phase_cnt <= 4'd0;
      edge_cnt  <= 5'd0;
      tog_cnt   <= 4'd0;
      sclk      <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      err_both  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Idle level follows the live cpol until a mode has been captured
          sclk <= mode_vld ? mode_cpol(mode_q) : cpol;
          if (accept) begin
            mode_q    <= spi_mode_e'({cpha, cpol});
            lsb_q     <= lsb_first;
            mode_vld  <= 1'b1;
            sclk      <= cpol;
            phase_cnt <= 4'd0;
            edge_cnt  <= 5'd0;
            tog_cnt   <= 4'd0;
          end
        end
        LEAD: begin
          phase_cnt <= lead_last ? 4'd0 : phase_cnt + 4'd1;
        end
        SHIFT: begin
          if (edge_any) begin
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 5'd1;
          end
          if (tog) tog_cnt <= tog_cnt + 4'd1;
          if (sampling_edge && toggling_edge) err_both <= 1'b1;
        end
        TRAIL: begin
          if (trail_last) begin
            phase_cnt <= 4'd0;
            edge_cnt  <= 5'd0;
            tog_cnt   <= 4'd0;
            rx_data   <= rx_q;
            rx_valid  <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine. The bench plays the edge
// generator and, when not looping mosi back, a slave driving miso.
module tb_spi_shift_engine;

  localparam int SS_LEAD  = 3;
  localparam int SS_TRAIL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       cpol, cpha, lsb_first;
  logic       toggling_edge, sampling_edge;
  logic       tx_dp, sclk, mosi, ss_n;
  wire        miso;
  logic [7:0] rx_data;
  logic       rx_valid, busy;

  logic loop_mode, slave_bit;
  assign miso = loop_mode ? mosi : slave_bit;

  always #5 clk = ~clk;

  spi_shift_engine #(.SS_LEAD(SS_LEAD), .SS_TRAIL(SS_TRAIL)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .toggling_edge(toggling_edge), .sampling_edge(sampling_edge), .tx_dp(tx_dp),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Observations from the most recent transfer
  logic [7:0] got_rx;
  logic       mosi_q[$];
  int         dp_cnt, rxv_cnt, sclk_tog, lead_cycles, trail_gap, edge_cnt_at_dp;
  logic       sclk_before, sclk_after, mosi_after, ss_after;
  bit         timeout;

  // Reference: i-th bit on the wire for a byte in the given order
  function automatic logic exp_bit(input logic [7:0] d, input logic lsb, input int i);
    return lsb ? d[i] : d[7-i];
  endfunction

  // Runs one transfer, acting as edge generator and slave, and records what it saw
  task automatic run_xfer(input logic [7:0] d, input logic pol, input logic pha,
                          input logic lsb, input logic loopb, input logic [7:0] pat,
                          input int period, input int poke_at, input int both_at,
                          input int abort_at, input bit spur);
    int cyc, edges, wait_cnt, poke_left, last_edge_cyc, n, s;
    bit seen_dp, done, samp_n;
    logic sclk_prev;
    mosi_q.delete();
    dp_cnt = 0; rxv_cnt = 0; sclk_tog = 0; lead_cycles = 0; trail_gap = -1;
    edge_cnt_at_dp = -1; timeout = 0; got_rx = 8'h00;
    sclk_before = 1'bx; sclk_after = 1'bx; mosi_after = 1'bx; ss_after = 1'bx;
    loop_mode = loopb; slave_bit = 1'b0;
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = d; cpol = pol; cpha = pha; lsb_first = lsb;
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_data = 8'($urandom);
    cpol = 1'($urandom); cpha = 1'($urandom); lsb_first = 1'($urandom);
    seen_dp = 0; done = 0; cyc = 0; edges = 0; wait_cnt = 0; poke_left = 0;
    last_edge_cyc = 0; sclk_prev = sclk;
    while (!done && cyc < 600) begin
      @(negedge clk);
      if (!seen_dp && !ss_n) lead_cycles++;
      if (tx_dp) begin
        dp_cnt++;
        if (!seen_dp) begin
          seen_dp = 1;
          sclk_before = sclk;
          edge_cnt_at_dp = int'(dut.edge_cnt);
        end
      end else if (seen_dp && sclk !== sclk_prev) begin
        sclk_tog++;
      end
      sclk_prev = sclk;
      if (seen_dp && sampling_edge) mosi_q.push_back(mosi);
      if (seen_dp && (sampling_edge || toggling_edge)) last_edge_cyc = cyc;
      if (rx_valid) begin
        rxv_cnt++; got_rx = rx_data; sclk_after = sclk; mosi_after = mosi; ss_after = ss_n;
        trail_gap = cyc - last_edge_cyc; done = 1;
      end
      @(posedge clk); #1;
      toggling_edge = 1'b0; sampling_edge = 1'b0;
      if (poke_left > 0) begin
        poke_left--;
        if (poke_left == 0) tx_valid = 1'b0;
      end
      if (abort_at > 0 && edges == abort_at) begin
        tx_valid = 1'b0;
        rst = 1'b1;
        return;
      end
      if (!seen_dp && spur) begin
        if (cyc % 2 == 0) toggling_edge = 1'b1;
        else sampling_edge = 1'b1;
      end else if (seen_dp && edges < 16) begin
        if (wait_cnt == 0) begin
          n = edges + 1;
          samp_n = pha ? (n % 2 == 0) : (n % 2 == 1);
          if (samp_n) begin
            s = (n - 1) / 2;
            slave_bit = lsb ? pat[s] : pat[7-s];
            sampling_edge = 1'b1;
            if (n == both_at) toggling_edge = 1'b1;
          end else begin
            toggling_edge = 1'b1;
          end
          edges = n;
          wait_cnt = period - 1;
          if (n == poke_at) begin
            tx_valid = 1'b1; tx_data = 8'hFF; poke_left = 3;
          end
        end else begin
          wait_cnt--;
        end
      end
      cyc++;
    end
    toggling_edge = 1'b0; sampling_edge = 1'b0;
    if (!done) timeout = 1;
    repeat (SS_LEAD + SS_TRAIL + 4) begin
      @(negedge clk);
      if (rx_valid) rxv_cnt++;
      if (tx_dp) dp_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    vectors++; if (ss_n !== 1'b1) begin miscompares++; $display("FAIL reset_ss_n: got %b expected 1", ss_n); end
    vectors++; if (sclk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    vectors++; if (mosi !== 1'b0) begin miscompares++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    vectors++; if (tx_dp !== 1'b0) begin miscompares++; $display("FAIL reset_tx_dp: got %b expected 0", tx_dp); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    vectors++; if (dut.err_both !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", dut.err_both); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_mode0();
    run_xfer(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3, 0, 0, 0, 0);
    vectors++; if (timeout) begin miscompares++; $display("FAIL mode0_timeout: no rx_valid within bound"); end
    vectors++; if (got_rx !== 8'hA5) begin miscompares++; $display("FAIL mode0_rx: got %h expected a5", got_rx); end
    vectors++; if (rxv_cnt != 1) begin miscompares++; $display("FAIL mode0_rxv_cnt: got %0d expected 1", rxv_cnt); end
    vectors++; if (dp_cnt != 1) begin miscompares++; $display("FAIL mode0_dp_cnt: got %0d expected 1", dp_cnt); end
    vectors++; if (lead_cycles != SS_LEAD) begin miscompares++; $display("FAIL mode0_lead: got %0d expected %0d", lead_cycles, SS_LEAD); end
    vectors++; if (trail_gap != SS_TRAIL + 1) begin miscompares++; $display("FAIL mode0_trail: got %0d expected %0d", trail_gap, SS_TRAIL + 1); end
    vectors++; if (mosi_q.size() != 8) begin miscompares++; $display("FAIL mode0_nsamp: got %0d expected 8", mosi_q.size()); end
    for (int i = 0; i < 8 && i < mosi_q.size(); i++) begin
      vectors++;
      if (mosi_q[i] !== exp_bit(8'hA5, 1'b0, i)) begin
        miscompares++; $display("FAIL mode0_mosi[%0d]: got %b expected %b", i, mosi_q[i], exp_bit(8'hA5, 1'b0, i));
      end
    end
  endtask

  task automatic test_mode3();
    run_xfer(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 2, 0, 0, 0, 0);
    vectors++; if (got_rx !== 8'hC3) begin miscompares++; $display("FAIL mode3_rx: got %h expected c3", got_rx); end
    vectors++; if (sclk_before !== 1'b1) begin miscompares++; $display("FAIL mode3_sclk_before: got %b expected 1", sclk_before); end
    vectors++; if (sclk_after !== 1'b1) begin miscompares++; $display("FAIL mode3_sclk_after: got %b expected 1", sclk_after); end
    vectors++; if (sclk_tog != 16) begin miscompares++; $display("FAIL mode3_sclk_tog: got %0d expected 16", sclk_tog); end
    for (int i = 0; i < 8 && i < mosi_q.size(); i++) begin
      vectors++;
      if (mosi_q[i] !== exp_bit(8'h3C, 1'b0, i)) begin
        miscompares++; $display("FAIL mode3_mosi[%0d]: got %b expected %b", i, mosi_q[i], exp_bit(8'h3C, 1'b0, i));
      end
    end
    @(negedge clk);
    vectors++; if (sclk !== 1'b1) begin miscompares++; $display("FAIL mode3_sclk_idle: got %b expected 1", sclk); end
  endtask

  task automatic test_lsb_mode1();
    run_xfer(8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 3, 0, 0, 0, 0);
    vectors++; if (got_rx !== 8'h01) begin miscompares++; $display("FAIL lsb_rx: got %h expected 01", got_rx); end
    vectors++; if (sclk_tog != 16) begin miscompares++; $display("FAIL lsb_sclk_tog: got %0d expected 16", sclk_tog); end
    vectors++; if (mosi_q.size() != 8) begin miscompares++; $display("FAIL lsb_nsamp: got %0d expected 8", mosi_q.size()); end
    for (int i = 0; i < 8 && i < mosi_q.size(); i++) begin
      vectors++;
      if (mosi_q[i] !== (i == 0 ? 1'b1 : 1'b0)) begin
        miscompares++; $display("FAIL lsb_mosi[%0d]: got %b expected %b", i, mosi_q[i], (i == 0 ? 1'b1 : 1'b0));
      end
    end
  endtask

  task automatic test_busy_ignore();
    run_xfer(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3, 6, 0, 0, 0);
    vectors++; if (got_rx !== 8'h5A) begin miscompares++; $display("FAIL busy_rx: got %h expected 5a", got_rx); end
    vectors++; if (rxv_cnt != 1) begin miscompares++; $display("FAIL busy_rxv_cnt: got %0d expected 1", rxv_cnt); end
    vectors++; if (dp_cnt != 1) begin miscompares++; $display("FAIL busy_dp_cnt: got %0d expected 1", dp_cnt); end
    @(negedge clk);
    vectors++; if (ss_n !== 1'b1) begin miscompares++; $display("FAIL busy_ss_idle: got %b expected 1", ss_n); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL busy_ready_idle: got %b expected 1", tx_ready); end
    run_xfer(8'hC7, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2, 0, 0, 0, 0);
    vectors++; if (got_rx !== 8'hC7) begin miscompares++; $display("FAIL busy_next_rx: got %h expected c7", got_rx); end
  endtask

  task automatic test_spurious();
    logic s0;
    @(negedge clk);
    s0 = sclk;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      toggling_edge = (i % 2 == 0); sampling_edge = (i % 2 == 1);
      @(negedge clk);
      vectors++; if (sclk !== s0) begin miscompares++; $display("FAIL spur_idle_sclk: got %b expected %b", sclk, s0); end
      vectors++; if (dut.edge_cnt !== 5'd0) begin miscompares++; $display("FAIL spur_idle_cnt: got %0d expected 0", dut.edge_cnt); end
    end
    @(posedge clk); #1;
    toggling_edge = 1'b0; sampling_edge = 1'b0;
    run_xfer(8'h96, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 2, 0, 0, 0, 1);
    vectors++; if (edge_cnt_at_dp != 0) begin miscompares++; $display("FAIL spur_lead_cnt: got %0d expected 0", edge_cnt_at_dp); end
    vectors++; if (sclk_before !== 1'b0) begin miscompares++; $display("FAIL spur_lead_sclk: got %b expected 0", sclk_before); end
    vectors++; if (sclk_tog != 16) begin miscompares++; $display("FAIL spur_sclk_tog: got %0d expected 16", sclk_tog); end
    vectors++; if (got_rx !== 8'h96) begin miscompares++; $display("FAIL spur_rx: got %h expected 96", got_rx); end
  endtask

  task automatic test_both_illegal();
    run_xfer(8'hE1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3, 0, 5, 0, 0);
    vectors++; if (dut.err_both !== 1'b1) begin miscompares++; $display("FAIL both_err: got %b expected 1", dut.err_both); end
    vectors++; if (got_rx !== 8'hE1) begin miscompares++; $display("FAIL both_rx: got %h expected e1", got_rx); end
    vectors++; if (sclk_tog != 16) begin miscompares++; $display("FAIL both_sclk_tog: got %0d expected 16", sclk_tog); end
  endtask

  task automatic test_reset_mid();
    int extra_rxv;
    run_xfer(8'h3B, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2, 0, 0, 5, 0);
    @(negedge clk);
    vectors++; if (ss_n !== 1'b1) begin miscompares++; $display("FAIL abort_ss_n: got %b expected 1", ss_n); end
    vectors++; if (sclk !== 1'b0) begin miscompares++; $display("FAIL abort_sclk: got %b expected 0", sclk); end
    vectors++; if (mosi !== 1'b0) begin miscompares++; $display("FAIL abort_mosi: got %b expected 0", mosi); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %b expected 1", tx_ready); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL abort_rx_valid: got %b expected 0", rx_valid); end
    vectors++; if (dut.err_both !== 1'b0) begin miscompares++; $display("FAIL abort_err: got %b expected 0", dut.err_both); end
    @(posedge clk); #1;
    rst = 1'b0;
    extra_rxv = 0;
    repeat (20) begin
      @(negedge clk);
      if (rx_valid || tx_dp) extra_rxv++;
    end
    vectors++; if (extra_rxv != 0) begin miscompares++; $display("FAIL abort_quiet: got %0d pulses expected 0", extra_rxv); end
    vectors++; if (dut.edge_cnt !== 5'd0) begin miscompares++; $display("FAIL abort_cnt: got %0d expected 0", dut.edge_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] d, pat, exp_rx;
    logic pol, pha, lsb, lb;
    for (int t = 0; t < 16; t++) begin
      d = 8'($urandom); pat = 8'($urandom);
      pol = 1'($urandom); pha = 1'($urandom); lsb = 1'($urandom); lb = 1'($urandom);
      run_xfer(d, pol, pha, lsb, lb, pat, int'($urandom_range(2, 4)), 0, 0, 0, 0);
      exp_rx = lb ? d : pat;
      vectors++; if (timeout) begin miscompares++; $display("FAIL rnd%0d_timeout: no rx_valid within bound", t); end
      vectors++; if (got_rx !== exp_rx) begin miscompares++; $display("FAIL rnd%0d_rx: got %h expected %h", t, got_rx, exp_rx); end
      vectors++; if (rxv_cnt != 1 || dp_cnt != 1) begin miscompares++; $display("FAIL rnd%0d_pulses: got rxv %0d dp %0d expected 1 1", t, rxv_cnt, dp_cnt); end
      vectors++; if (sclk_tog != 16) begin miscompares++; $display("FAIL rnd%0d_sclk_tog: got %0d expected 16", t, sclk_tog); end
      vectors++; if (sclk_before !== pol || sclk_after !== pol) begin miscompares++; $display("FAIL rnd%0d_sclk_idle: got %b/%b expected %b", t, sclk_before, sclk_after, pol); end
      vectors++; if (mosi_after !== 1'b0 || ss_after !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_end: got mosi %b ss_n %b expected 0 1", t, mosi_after, ss_after); end
      vectors++; if (mosi_q.size() != 8) begin miscompares++; $display("FAIL rnd%0d_nsamp: got %0d expected 8", t, mosi_q.size()); end
      for (int i = 0; i < 8 && i < mosi_q.size(); i++) begin
        vectors++;
        if (mosi_q[i] !== exp_bit(d, lsb, i)) begin
          miscompares++; $display("FAIL rnd%0d_mosi[%0d]: got %b expected %b", t, i, mosi_q[i], exp_bit(d, lsb, i));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    toggling_edge = 1'b0; sampling_edge = 1'b0;
    loop_mode = 1'b1; slave_bit = 1'b0;
    test_reset();
    test_mode0();
    test_mode3();
    test_lsb_mode1();
    test_busy_ignore();
    test_spurious();
    test_both_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
